ex_alu_sequencer: RTL

- Execution-stage initiator for the combinational ALU: accepts one decoded instruction, drives the ALU request interface (alu_ex_signal, ex_stage_state, opcode, operands) and waits for the alu_stall acknowledge.
- Captures result/sign_bits and produces a single execution result to the next stage.
- Branches use two ALU transactions: BRANCHCOND, then PCBASED for the target.
- Sits between decode and memory/writeback.

---
 rtl/ex_alu_sequencer_pkg.sv | 50 +++++
 rtl/ex_alu_sequencer_handshake.sv | 40 ++++
 rtl/ex_alu_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ex_alu_sequencer_pkg.sv
// Shared class, opcode, sign and state encodings for the execution-stage ALU sequencer.
// The branch helper turns the sign of the first (compare) transaction into a taken decision.
package ex_alu_sequencer_pkg;

  typedef enum logic [2:0] {
    CLS_BRANCHCOND = 3'd0,
    CLS_MEMADDR    = 3'd1,
    CLS_IMMEXPR    = 3'd2,
    CLS_BINARYEXPR = 3'd3,
    CLS_PCBASED    = 3'd4,
    CLS_IMMONLY    = 3'd5
  } ex_class_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;
  localparam logic [3:0] OP_BLT  = 4'd10;
  localparam logic [3:0] OP_BGE  = 4'd11;

  localparam logic [1:0] SIGN_ZERO = 2'b00;
  localparam logic [1:0] SIGN_POS  = 2'b01;
  localparam logic [1:0] SIGN_NEG  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_REQ2     = 3'd3,
    ST_RELEASE2 = 3'd4,
    ST_DONE     = 3'd5
  } seq_state_e;

  // Codes outside the defined set are executed as an immediate passthrough.
  function automatic ex_class_e normalize_class(input logic [2:0] cls);
    if (cls > 3'd5) return CLS_IMMONLY;
    return ex_class_e'(cls);
  endfunction

  function automatic logic branch_decision(input logic [3:0] op, input logic [1:0] sign);
    case (op)
      OP_BEQ:  return (sign == SIGN_ZERO);
      OP_BNE:  return (sign != SIGN_ZERO);
      OP_BLT:  return (sign == SIGN_NEG);
      OP_BGE:  return (sign == SIGN_POS) || (sign == SIGN_ZERO);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_alu_sequencer_handshake.sv
// Request/acknowledge/return-to-zero handshake tracker with a shared timeout counter.
// The same instance serves both ALU transactions of a branch.
module alu_handshake_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_phase,
  input  logic rel_phase,
  input  logic alu_stall,
  output logic ack,
  output logic released,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;
  logic          waiting;

  assign ack      = req_phase && alu_stall;
  assign released = rel_phase && !alu_stall;
  assign waiting  = (req_phase && !alu_stall) || (rel_phase && alu_stall);
  // Fires on the cycle whose increment would bring the counter to TIMEOUT.
  assign timeout  = waiting && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      if (!waiting || timeout) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ex_alu_sequencer.sv
// Execution-stage initiator: issues one or two ALU transactions per decoded instruction
// and hands a single result (value, rd, branch decision/target) to the next stage.
module ex_alu_sequencer
  import ex_alu_sequencer_pkg::*;
#(
  parameter int LEN     = 32,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy_in,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     in_class,
  input  logic [3:0]     in_op,
  input  logic [LEN-1:0] in_rs1,
  input  logic [LEN-1:0] in_rs2,
  input  logic [LEN-1:0] in_imm,
  input  logic [LEN-1:0] in_pc,
  input  logic [4:0]     in_rd,
  output logic           alu_ex_signal,
  output logic [2:0]     ex_stage_state,
  output logic [3:0]     opcode,
  output logic [LEN-1:0] rs1,
  output logic [LEN-1:0] rs2,
  output logic [LEN-1:0] imm,
  output logic [LEN-1:0] pc,
  input  logic           alu_stall,
  input  logic [LEN-1:0] result,
  input  logic [1:0]     sign_bits,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] out_value,
  output logic [4:0]     out_rd,
  output logic           br_taken,
  output logic [LEN-1:0] br_target,
  output logic           err
);

  seq_state_e     state, next_state;
  ex_class_e      lat_class;
  logic [3:0]     lat_op;
  logic [LEN-1:0] lat_rs1, lat_rs2, lat_imm, lat_pc;
  logic [1:0]     sign_q;
  logic           req_phase, rel_phase, second_pass;
  logic           ack, released, timeout, accept;

  assign req_phase   = (state == ST_REQ) || (state == ST_REQ2);
  assign rel_phase   = (state == ST_RELEASE) || (state == ST_RELEASE2);
  assign second_pass = (state == ST_REQ2) || (state == ST_RELEASE2);

  alu_handshake_ctrl #(
    .TIMEOUT(TIMEOUT)
  ) u_handshake (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy_in),
    .req_phase (req_phase),
    .rel_phase (rel_phase),
    .alu_stall (alu_stall),
    .ack       (ack),
    .released  (released),
    .timeout   (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (rdy_in) begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    in_ready      = 1'b0;
    alu_ex_signal = 1'b0;
    out_valid     = 1'b0;
    accept        = 1'b0;
    case (state)
      ST_IDLE: begin
        // A still-busy ALU blocks acceptance until it returns to zero.
        in_ready = !alu_stall;
        if (in_valid && !alu_stall) begin
          accept     = 1'b1;
          next_state = ST_REQ;
        end
      end
      ST_REQ, ST_REQ2: begin
        alu_ex_signal = 1'b1;
        if (timeout) begin
          next_state = ST_DONE;
        end else if (ack) begin
          next_state = (state == ST_REQ) ? ST_RELEASE : ST_RELEASE2;
        end
      end
      ST_RELEASE: begin
        if (timeout) begin
          next_state = ST_DONE;
        end else if (released) begin
          next_state = (lat_class == CLS_BRANCHCOND) ? ST_REQ2 : ST_DONE;
        end
      end
      ST_RELEASE2: begin
        if (timeout || released) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // The target computation reuses the latched operands; only the class changes.
  assign ex_stage_state = second_pass ? CLS_PCBASED : lat_class;
  assign opcode         = lat_op;
  assign rs1            = lat_rs1;
  assign rs2            = lat_rs2;
  assign imm            = lat_imm;
  assign pc             = lat_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_class <= CLS_BRANCHCOND;
      lat_op    <= '0;
      lat_rs1   <= '0;
      lat_rs2   <= '0;
      lat_imm   <= '0;
      lat_pc    <= '0;
      out_rd    <= '0;
      out_value <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
      sign_q    <= SIGN_ZERO;
      err       <= 1'b0;
    end else if (rdy_in) begin
      if (timeout) begin
        err       <= 1'b1;
        out_value <= '0;
        br_taken  <= 1'b0;
        br_target <= '0;
      end else if (accept) begin
        lat_class <= normalize_class(in_class);
        lat_op    <= in_op;
        lat_rs1   <= in_rs1;
        lat_rs2   <= in_rs2;
        lat_imm   <= in_imm;
        lat_pc    <= in_pc;
        out_rd    <= in_rd;
        out_value <= '0;
        br_taken  <= 1'b0;
        br_target <= '0;
        sign_q    <= SIGN_ZERO;
      end else if (ack) begin
        // The branch compare result is only needed for its sign.
        if (state == ST_REQ) begin
          sign_q <= sign_bits;
          if (lat_class != CLS_BRANCHCOND) begin
            out_value <= result;
          end
        end else begin
          br_target <= result;
          br_taken  <= branch_decision(lat_op, sign_q);
        end
      end
    end
  end

endmodule
